keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/keypad_code.sv | 37 +++
 rtl/keypad_scanner.sv | 239 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: default timing, FSM state
// encoding, frame-result encoding and the row/column to digit map.
package keypad_pkg;

  localparam int SCAN_CYCLES_DEF = 4;
  localparam int DEBOUNCE_DEF    = 3;

  // Debounce FSM states
  localparam logic [1:0] ST_ARMED   = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // Frame classification results
  localparam logic [1:0] FR_NONE  = 2'd0;
  localparam logic [1:0] FR_KEY   = 2'd1;
  localparam logic [1:0] FR_GHOST = 2'd2;

  // Digit printed on the key at (row, col); row 3 (g) only carries 0 on col b
  function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] n;
    if (row == 2'd3) begin
      n = 4'd0;
    end else begin
      n = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_code.sv
// Combinational decode of one row's column sense lines into
// {hit, multi, number}. Unmapped positions on row g are ignored.
module keypad_code
  import keypad_pkg::*;
(
  input  logic [1:0] row,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       hit,
  output logic       multi,
  output logic [3:0] number
);

  logic [2:0] cols_s;

  // Mask unmapped columns, then flag any/multiple closures and name the key
  always_comb begin
    if (row == 2'd3) begin
      cols_s = {1'b0, b, 1'b0};
    end else begin
      cols_s = {c, b, a};
    end
    hit   = |cols_s;
    multi = (cols_s[0] & cols_s[1]) | (cols_s[0] & cols_s[2]) | (cols_s[1] & cols_s[2]);
    if (cols_s[0]) begin
      number = key_at(row, 2'd0);
    end else if (cols_s[1]) begin
      number = key_at(row, 2'd1);
    end else if (cols_s[2]) begin
      number = key_at(row, 2'd2);
    end else begin
      number = 4'd0;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: one-hot row drive, per-frame classification,
// debounce FSM and a single-entry key holding register with overrun flag.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES = SCAN_CYCLES_DEF,
  parameter int DEBOUNCE    = DEBOUNCE_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       key_valid,
  output logic [3:0] key_number,
  input  logic       key_ready,
  output logic       overrun
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1'b1);

  logic [CW-1:0] cyc_r;
  logic [1:0]    row_idx_r;
  logic [3:0]    row_oh_r;
  logic          slot_end_s, frame_end_s;

  logic          code_hit_s, code_multi_s;
  logic [3:0]    code_num_s;

  logic          seen_r, ghost_r;
  logic [3:0]    num_r;
  logic          acc_seen_s, acc_ghost_s;
  logic [3:0]    acc_num_s;
  logic [1:0]    frame_res_s;
  logic          frame_vld_r;
  logic [1:0]    frame_res_r;
  logic [3:0]    frame_num_r;

  logic [1:0]    state_r, state_s;
  logic [3:0]    cand_r, cand_s;
  logic [DW-1:0] cnt_r, cnt_s;
  logic          accept_s, consume_s;

  logic          valid_r, overrun_r;
  logic [3:0]    number_r;

  assign slot_end_s  = (cyc_r == CYC_LAST);
  assign frame_end_s = slot_end_s & (row_idx_r == 2'd3);
  assign consume_s   = valid_r & key_ready;

  keypad_code u_code (
    .row    (row_idx_r),
    .a      (a),
    .b      (b),
    .c      (c),
    .hit    (code_hit_s),
    .multi  (code_multi_s),
    .number (code_num_s)
  );

  // Row scan: hold each row SCAN_CYCLES cycles, rotate d->e->f->g->d
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cyc_r     <= {CW{1'b0}};
      row_idx_r <= 2'd0;
      row_oh_r  <= 4'b0001;
    end else if (slot_end_s) begin
      cyc_r     <= {CW{1'b0}};
      row_idx_r <= row_idx_r + 2'd1;
      row_oh_r  <= {row_oh_r[2:0], row_oh_r[3]};
    end else begin
      cyc_r     <= cyc_r + CW'(1'b1);
      row_idx_r <= row_idx_r;
      row_oh_r  <= row_oh_r;
    end
  end

  // Fold the current row's decode into the running frame accumulation
  always_comb begin
    acc_seen_s  = seen_r;
    acc_ghost_s = ghost_r;
    acc_num_s   = num_r;
    if (code_multi_s || (code_hit_s && seen_r)) begin
      acc_ghost_s = 1'b1;
    end else if (code_hit_s) begin
      acc_seen_s = 1'b1;
      acc_num_s  = code_num_s;
    end else begin
      acc_seen_s = seen_r;
    end
    if (acc_ghost_s) begin
      frame_res_s = FR_GHOST;
    end else if (acc_seen_s) begin
      frame_res_s = FR_KEY;
    end else begin
      frame_res_s = FR_NONE;
    end
  end

  // Frame accumulator: sample on each slot's last cycle, publish at frame end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      seen_r      <= 1'b0;
      ghost_r     <= 1'b0;
      num_r       <= 4'd0;
      frame_vld_r <= 1'b0;
      frame_res_r <= FR_NONE;
      frame_num_r <= 4'd0;
    end else if (frame_end_s) begin
      seen_r      <= 1'b0;
      ghost_r     <= 1'b0;
      num_r       <= 4'd0;
      frame_vld_r <= 1'b1;
      frame_res_r <= frame_res_s;
      frame_num_r <= acc_num_s;
    end else if (slot_end_s) begin
      seen_r      <= acc_seen_s;
      ghost_r     <= acc_ghost_s;
      num_r       <= acc_num_s;
      frame_vld_r <= 1'b0;
    end else begin
      frame_vld_r <= 1'b0;
    end
  end

  // Debounce FSM: evaluated once per published frame result
  always_comb begin
    state_s  = state_r;
    cand_s   = cand_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    if (frame_vld_r) begin
      case (state_r)
        ST_ARMED: begin
          if (frame_res_r == FR_KEY) begin
            cand_s = frame_num_r;
            if (DEB_MAX <= DEB_ONE) begin
              accept_s = 1'b1;
              state_s  = ST_LOCKED;
              cnt_s    = {DW{1'b0}};
            end else begin
              state_s = ST_CONFIRM;
              cnt_s   = DEB_ONE;
            end
          end else begin
            state_s = ST_ARMED;
          end
        end
        ST_CONFIRM: begin
          if (frame_res_r == FR_KEY) begin
            if (frame_num_r == cand_r) begin
              if ((cnt_r + DEB_ONE) >= DEB_MAX) begin
                accept_s = 1'b1;
                state_s  = ST_LOCKED;
                cnt_s    = {DW{1'b0}};
              end else begin
                cnt_s = cnt_r + DEB_ONE;
              end
            end else begin
              cand_s = frame_num_r;
              cnt_s  = DEB_ONE;
            end
          end else begin
            state_s = ST_ARMED;
            cnt_s   = {DW{1'b0}};
          end
        end
        ST_LOCKED: begin
          if (frame_res_r == FR_NONE) begin
            if ((cnt_r + DEB_ONE) >= DEB_MAX) begin
              state_s = ST_ARMED;
              cnt_s   = {DW{1'b0}};
            end else begin
              cnt_s = cnt_r + DEB_ONE;
            end
          end else begin
            cnt_s = {DW{1'b0}};
          end
        end
        default: begin
          state_s = ST_ARMED;
          cnt_s   = {DW{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r <= ST_ARMED;
      cand_r  <= 4'd0;
      cnt_r   <= {DW{1'b0}};
    end else begin
      state_r <= state_s;
      cand_r  <= cand_s;
      cnt_r   <= cnt_s;
    end
  end

  // Key holding register: load on accept, clear on consume, flag dropped keys
  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_r   <= 1'b0;
      number_r  <= 4'd0;
      overrun_r <= 1'b0;
    end else if (accept_s && (!valid_r || consume_s)) begin
      valid_r   <= 1'b1;
      number_r  <= frame_num_r;
      overrun_r <= 1'b0;
    end else if (accept_s) begin
      overrun_r <= 1'b1;
    end else if (consume_s) begin
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
    end
  end

  assign d          = row_oh_r[0];
  assign e          = row_oh_r[1];
  assign f          = row_oh_r[2];
  assign g          = row_oh_r[3];
  assign key_valid  = valid_r;
  assign key_number = number_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates the key matrix from a per-frame press
// mask and compares every cycle against a frame-level behavioural model.
module tb_keypad_scanner;

  localparam int SC    = 4;
  localparam int DEB   = 3;
  localparam int FRAME = 4 * SC;

  logic clock = 1'b0;
  logic resetn, a, b, c, key_ready;
  logic d, e, f, g, key_valid, overrun;
  logic [3:0] key_number;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int         mt;
  logic [11:0] mask;
  int         ready_mode;
  bit         mv, mover;
  int         mnum;
  bit         pend;
  int         pend_kind, pend_num;
  int         cand, run_len, quiet;
  bit         held;
  int         first_valid, valid_cnt, ov_cnt;

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE(DEB)) dut (
    .clock(clock), .resetn(resetn), .a(a), .b(b), .c(c),
    .d(d), .e(e), .f(f), .g(g),
    .key_valid(key_valid), .key_number(key_number),
    .key_ready(key_ready), .overrun(overrun)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", tag, mt, got, exp);
    end
  endtask

  // mask bit index of the key at (row, col); 10/11 are row g's blank positions
  function automatic int key_idx(input int row, input int col);
    if (row < 3) return row * 3 + col + 1;
    else if (col == 1) return 0;
    else if (col == 0) return 10;
    else return 11;
  endfunction

  task automatic model_reset();
    mt = 0; mv = 1'b0; mnum = 0; mover = 1'b0; pend = 1'b0;
    cand = -1; run_len = 0; quiet = 0; held = 1'b0;
  endtask

  task automatic clear_stats();
    first_valid = -1; valid_cnt = 0; ov_cnt = 0;
  endtask

  // debounce rules in frame terms; cand = -1 means nothing pending
  task automatic frame_step(input int kind, input int num, output bit acc);
    acc = 1'b0;
    if (held) begin
      if (kind == 0) begin
        quiet++;
        if (quiet == DEB) begin held = 1'b0; quiet = 0; cand = -1; run_len = 0; end
      end else begin
        quiet = 0;
      end
    end else if (kind == 1) begin
      if (cand == num) run_len++;
      else begin cand = num; run_len = 1; end
      if (run_len == DEB) begin acc = 1'b1; held = 1'b1; quiet = 0; cand = -1; run_len = 0; end
    end else begin
      cand = -1; run_len = 0;
    end
  endtask

  task automatic model_advance();
    bit consume, acc;
    int n, k, accnum;
    consume = mv && key_ready;
    acc = 1'b0;
    accnum = pend_num;
    if (pend) begin
      pend = 1'b0;
      frame_step(pend_kind, pend_num, acc);
    end
    mover = 1'b0;
    if (acc) begin
      if (!mv || consume) begin mv = 1'b1; mnum = accnum; end
      else mover = 1'b1;
    end else if (consume) begin
      mv = 1'b0;
    end
    if ((mt % FRAME) == FRAME - 1) begin
      n = 0; k = 0;
      for (int i = 0; i < 10; i++) if (mask[i]) begin n++; k = i; end
      pend = 1'b1;
      pend_kind = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
      pend_num = k;
    end
    mt++;
  endtask

  // one clock cycle: drive, compare, advance model, move to next negedge
  task automatic step(input bit rst);
    int r;
    logic [3:0] exp_rows;
    r = (mt / SC) % 4;
    resetn = ~rst;
    a = mask[key_idx(r, 0)];
    b = mask[key_idx(r, 1)];
    c = mask[key_idx(r, 2)];
    key_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    exp_rows = 4'b0001 << r;
    check_val("rows", 32'({g, f, e, d}), 32'(exp_rows));
    check_val("key_valid", 32'(key_valid), 32'(mv));
    check_val("key_number", 32'(key_number), mnum);
    check_val("overrun", 32'(overrun), 32'(mover));
    if (key_valid === 1'b1) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = mt;
    end
    if (overrun === 1'b1) ov_cnt++;
    if (rst) model_reset();
    else model_advance();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_cycles(input logic [11:0] m, input int n);
    mask = m;
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic run_frames(input logic [11:0] m, input int n);
    run_cycles(m, n * FRAME);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  int sel, hold, i1, j1;
  logic [11:0] rm;

  initial begin
    resetn = 1'b0; key_ready = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    mask = 12'h000; ready_mode = 1;
    model_reset();
    clear_stats();
    repeat (2) @(posedge clock);
    @(negedge clock);
    do_reset(2);

    // idle: rows rotate, nothing reported
    ready_mode = 1;
    run_frames(12'h000, 7);

    // key 5 held from cycle 0: first valid at cycle 49, reported once
    do_reset(1);
    clear_stats();
    run_frames(12'h020, 6);
    check_val("latency", first_valid, 49);
    check_val("single_report", valid_cnt, 1);
    run_frames(12'h000, 4);

    // 8 for 2 frames, release, 8 for 3 frames: one key after the second press
    clear_stats();
    run_frames(12'h100, 2);
    run_frames(12'h000, 2);
    check_val("short_press", valid_cnt, 0);
    run_frames(12'h100, 3);
    run_frames(12'h000, 4);
    check_val("second_press", valid_cnt, 1);
    check_val("num8", 32'(key_number), 8);

    // 1 and 6 together is a ghost; then 0 alone
    clear_stats();
    run_frames(12'h042, 5);
    check_val("ghost", valid_cnt, 0);
    run_frames(12'h000, 3);
    run_frames(12'h001, 4);
    run_frames(12'h000, 4);
    check_val("key0_cnt", valid_cnt, 1);
    check_val("num0", 32'(key_number), 0);

    // consumer stalled: 3 kept, 9 dropped with one overrun pulse
    ready_mode = 0;
    clear_stats();
    run_frames(12'h008, 4);
    run_frames(12'h000, 3);
    run_frames(12'h200, 4);
    run_frames(12'h000, 3);
    check_val("overrun_cnt", ov_cnt, 1);
    check_val("num3_kept", 32'(key_number), 3);
    check_val("valid_held", 32'(key_valid), 1);
    ready_mode = 1;
    run_frames(12'h000, 2);
    check_val("consumed", 32'(key_valid), 0);
    check_val("num3_after", 32'(key_number), 3);

    // reset during confirmation of 7 discards progress
    do_reset(1);
    clear_stats();
    run_cycles(12'h080, 24);
    check_val("no_key_pre_rst", valid_cnt, 0);
    do_reset(1);
    check_val("d_after_rst", 32'(d), 1);
    clear_stats();
    run_frames(12'h080, 4);
    check_val("relatency", first_valid, 49);
    run_frames(12'h000, 4);

    // randomized press patterns, random consumer, occasional mid-frame reset
    ready_mode = 2;
    for (int k = 0; k < 40; k++) begin
      sel  = $urandom_range(0, 9);
      hold = $urandom_range(1, 5);
      rm   = 12'h000;
      case (sel)
        3, 4, 5, 6: rm[$urandom_range(0, 9)] = 1'b1;
        7: begin
          i1 = $urandom_range(0, 9);
          j1 = (i1 + $urandom_range(1, 9)) % 10;
          rm[i1] = 1'b1; rm[j1] = 1'b1;
        end
        8: rm[$urandom_range(10, 11)] = 1'b1;
        9: begin
          rm[$urandom_range(0, 9)] = 1'b1;
          rm[$urandom_range(10, 11)] = 1'b1;
        end
        default: rm = 12'h000;
      endcase
      if ($urandom_range(0, 11) == 0) begin
        run_cycles(rm, $urandom_range(1, 31));
        do_reset($urandom_range(1, 2));
      end else begin
        run_frames(rm, hold);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
